// File: rtl/fe_cap_pkg.sv
// Shared types and default sizing for the front-end capture buffer.
package fe_cap_pkg;

   localparam int LANE_WIDTH    = 16;
   localparam int DES_OUT_WIDTH = 4;
   localparam int ADC_WIDTH     = 8;
   localparam int DEPTH         = 64;
   localparam int NUM_SAMP      = LANE_WIDTH * DES_OUT_WIDTH;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARMED   = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_DONE    = 2'd3
   } state_e;

   typedef logic [NUM_SAMP-1:0][ADC_WIDTH-1:0] word_t;

endpackage

// File: rtl/fe_cap_ram.sv
// Depth x word capture storage: one write port, one registered read port.
module fe_cap_ram
   import fe_cap_pkg::*;
#(
   parameter  int NumSamp  = NUM_SAMP,
   parameter  int AdcWidth = ADC_WIDTH,
   parameter  int Depth    = DEPTH,
   localparam int AW       = $clog2(Depth)
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              i_wr_en,
   input  logic [AW-1:0]                     i_wr_addr,
   input  logic [NumSamp-1:0][AdcWidth-1:0]  i_wr_data,
   input  logic                              i_rd_en,
   input  logic [AW-1:0]                     i_rd_addr,
   output logic [NumSamp-1:0][AdcWidth-1:0]  o_rd_data
);

   logic [NumSamp-1:0][AdcWidth-1:0] mem_q [Depth];
   logic [NumSamp-1:0][AdcWidth-1:0] rd_data_d, rd_data_q;

   // NOTE: the storage array has no reset so it can map onto block RAM; only the read register is reset.
   always_ff @(posedge clk) begin
      if (i_wr_en) mem_q[i_wr_addr] <= i_wr_data;
   end

   // NOTE: every always_comb output is given a default first so no latch is inferred.
   always_comb begin
      rd_data_d = rd_data_q;
      if (i_rd_en) rd_data_d = mem_q[i_rd_addr];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) rd_data_q <= '0;
      else     rd_data_q <= rd_data_d;
   end

   assign o_rd_data = rd_data_q;

endmodule

// File: rtl/fe_cap_buf.sv
// Triggered capture of FE words into a Depth-entry buffer with decimation and readback.
// Optional threshold trigger is enabled by defining FE_CAP_THRESH_TRIG_EN.
module fe_cap_buf
   import fe_cap_pkg::*;
#(
   parameter  int LaneWidth   = LANE_WIDTH,
   parameter  int DesOutWidth = DES_OUT_WIDTH,
   parameter  int AdcWidth    = ADC_WIDTH,
   parameter  int Depth       = DEPTH,
   localparam int AW          = $clog2(Depth),
   localparam int NumSamp     = LaneWidth * DesOutWidth
) (
   input  logic                              i_clk_dig_mem,
   input  logic                              i_rst_mem,
   input  logic [NumSamp-1:0][AdcWidth-1:0]  i_dat_fe,
   input  logic                              i_arm,
   input  logic                              i_abort,
   input  logic                              i_ext_trig,
   input  logic                              i_trig_sel,
   input  logic [AdcWidth-1:0]               i_trig_thresh,
   input  logic [3:0]                        i_decim,
   input  logic                              i_rd_en,
   input  logic [AW-1:0]                     i_rd_addr,
   output logic [NumSamp-1:0][AdcWidth-1:0]  o_rd_data,
   output logic                              o_rd_valid,
   output logic [1:0]                        o_state,
   output logic                              o_done,
   output logic [AW:0]                       o_wr_cnt
);

   localparam logic [AW:0] DEPTH_CNT = (AW+1)'(Depth);
   localparam logic [AW:0] CNT_ONE   = (AW+1)'(1);

   state_e      state_d, state_q;
   logic [AW:0] wr_cnt_d, wr_cnt_q;
   logic        done_d, done_q;
   logic [3:0]  dec_cnt_d, dec_cnt_q;
   logic [3:0]  decim_d, decim_q;
   logic        rd_valid_d, rd_valid_q;
   logic        rd_accept;
   logic        wr_en;
   logic        trig;

`ifdef FE_CAP_THRESH_TRIG_EN
   logic thresh_hit;

   always_comb begin
      thresh_hit = 1'b0;
      for (int i = 0; i < NumSamp; i++) begin
         if (i_dat_fe[i] >= i_trig_thresh) thresh_hit = 1'b1;
      end
   end

   // Trigger source is only consulted while ARMED, i.e. on the trigger cycle itself.
   assign trig = i_trig_sel ? thresh_hit : i_ext_trig;
`else
   logic unused_trig_cfg;
   assign unused_trig_cfg = ^{i_trig_sel, i_trig_thresh};
   assign trig = i_ext_trig;
`endif

   // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
   always_ff @(posedge i_clk_dig_mem or posedge i_rst_mem) begin
      if (i_rst_mem) begin
         state_q    <= ST_IDLE;
         wr_cnt_q   <= '0;
         done_q     <= 1'b0;
         dec_cnt_q  <= '0;
         decim_q    <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_cnt_q   <= wr_cnt_d;
         done_q     <= done_d;
         dec_cnt_q  <= dec_cnt_d;
         decim_q    <= decim_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      wr_cnt_d  = wr_cnt_q;
      done_d    = done_q;
      dec_cnt_d = dec_cnt_q;
      decim_d   = decim_q;
      wr_en     = 1'b0;
      if (i_abort) begin
         state_d = ST_IDLE;
         done_d  = 1'b0;
      end else begin
         unique case (state_q)
            ST_IDLE, ST_DONE: begin
               if (i_arm) begin
                  state_d  = ST_ARMED;
                  done_d   = 1'b0;
                  wr_cnt_d = '0;
               end
            end
            ST_ARMED: begin
               if (trig) begin
                  state_d   = ST_CAPTURE;
                  wr_en     = 1'b1;
                  wr_cnt_d  = CNT_ONE;
                  decim_d   = i_decim;
                  dec_cnt_d = (i_decim == 4'd0) ? 4'd0 : 4'd1;
               end
            end
            ST_CAPTURE: begin
               // Full buffer: one more cycle here, then DONE, so o_done trails the last write.
               if (wr_cnt_q == DEPTH_CNT) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
               end else begin
                  if (dec_cnt_q == 4'd0) begin
                     wr_en    = 1'b1;
                     wr_cnt_d = wr_cnt_q + CNT_ONE;
                  end
                  dec_cnt_d = (dec_cnt_q == decim_q) ? 4'd0 : dec_cnt_q + 4'd1;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      rd_accept  = i_rd_en && (state_q == ST_IDLE || state_q == ST_DONE);
      rd_valid_d = rd_accept;
      o_state    = state_q;
      o_done     = done_q;
      o_wr_cnt   = wr_cnt_q;
      o_rd_valid = rd_valid_q;
   end

   fe_cap_ram #(
      .NumSamp  (NumSamp),
      .AdcWidth (AdcWidth),
      .Depth    (Depth)
   ) u_ram (
      .clk       (i_clk_dig_mem),
      .rst       (i_rst_mem),
      .i_wr_en   (wr_en),
      .i_wr_addr (wr_cnt_q[AW-1:0]),
      .i_wr_data (i_dat_fe),
      .i_rd_en   (rd_accept),
      .i_rd_addr (i_rd_addr),
      .o_rd_data (o_rd_data)
   );

endmodule

// File: tb/tb_fe_cap_buf.sv
// Scoreboarded bench for fe_cap_buf: reference words come from the stimulus history.
module tb_fe_cap_buf;
   import fe_cap_pkg::*;

   localparam int AW = $clog2(DEPTH);
   localparam int WB = $bits(word_t);

   logic                 clk = 1'b0;
   logic                 rst;
   word_t                i_dat_fe;
   logic                 i_arm, i_abort, i_ext_trig, i_trig_sel;
   logic [ADC_WIDTH-1:0] i_trig_thresh;
   logic [3:0]           i_decim;
   logic                 i_rd_en;
   logic [AW-1:0]        i_rd_addr;
   word_t                o_rd_data;
   logic                 o_rd_valid;
   logic [1:0]           o_state;
   logic                 o_done;
   logic [AW:0]          o_wr_cnt;

   word_t hist[$];
   word_t exp_q[$];
   int    checks = 0;
   int    errors = 0;

   always #5 clk = ~clk;

   fe_cap_buf dut (
      .i_clk_dig_mem (clk),
      .i_rst_mem     (rst),
      .i_dat_fe      (i_dat_fe),
      .i_arm         (i_arm),
      .i_abort       (i_abort),
      .i_ext_trig    (i_ext_trig),
      .i_trig_sel    (i_trig_sel),
      .i_trig_thresh (i_trig_thresh),
      .i_decim       (i_decim),
      .i_rd_en       (i_rd_en),
      .i_rd_addr     (i_rd_addr),
      .o_rd_data     (o_rd_data),
      .o_rd_valid    (o_rd_valid),
      .o_state       (o_state),
      .o_done        (o_done),
      .o_wr_cnt      (o_wr_cnt)
   );

   task automatic check(input string name, input logic [WB-1:0] act, input logic [WB-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic word_t ramp(input int v);
      word_t w;
      for (int i = 0; i < NUM_SAMP; i++) w[i] = v[ADC_WIDTH-1:0];
      return w;
   endfunction

   function automatic word_t rnd_word(input int maxv);
      word_t w;
      for (int i = 0; i < NUM_SAMP; i++) w[i] = ADC_WIDTH'($urandom_range(maxv, 0));
      return w;
   endfunction

   // One FE word per clock; inputs change 1 time unit after the edge.
   task automatic cycle(input word_t w);
      i_dat_fe = w;
      hist.push_back(w);
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input int addr, input word_t expw);
      i_rd_en   = 1'b1;
      i_rd_addr = addr[AW-1:0];
      exp_q.push_back(expw);
      cycle(rnd_word(255));
      i_rd_en = 1'b0;
   endtask

   // Monitor: every valid read beat must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (o_rd_valid) begin
         if (exp_q.size() == 0) check("rd_unexpected_valid", 1, 0);
         else                   check("rd_data", o_rd_data, exp_q.pop_front());
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int    t, cnt;
      word_t last_rd, w;

      rst = 1'b1; i_arm = 0; i_abort = 0; i_ext_trig = 0; i_trig_sel = 0;
      i_trig_thresh = '0; i_decim = '0; i_rd_en = 0; i_rd_addr = '0; i_dat_fe = '0;
      #12;
      check("rst_state", o_state, 0);
      check("rst_done", o_done, 0);
      check("rst_wr_cnt", o_wr_cnt, 0);
      check("rst_rd_valid", o_rd_valid, 0);
      check("rst_rd_data", o_rd_data, 0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Basic capture: ramp data, trigger on word 10, no decimation.
      i_arm = 1; cycle(ramp(0)); i_arm = 0;
      for (int v = 1; v < 10; v++) cycle(ramp(v));
      check("basic_armed", o_state, 1);
      i_ext_trig = 1; cycle(ramp(10)); i_ext_trig = 0;
      check("basic_capture", o_state, 2);
      check("basic_cnt1", o_wr_cnt, 1);
      cnt = 0;
      while (!o_done && cnt < 400) begin cycle(ramp(11 + cnt)); cnt++; end
      check("basic_done_latency", cnt, DEPTH);
      check("basic_state_done", o_state, 3);
      check("basic_wr_cnt", o_wr_cnt, DEPTH);
      rd(0, ramp(10));
      check("rd_valid_latency", o_rd_valid, 1);
      for (int k = 1; k < DEPTH; k++) rd(k, ramp(10 + k));
      cycle(ramp(0));
      check("rd_valid_drop", o_rd_valid, 0);
      check("rd_data_hold", o_rd_data, ramp(10 + DEPTH - 1));

      // Decimation by 4, trigger on word 5; decim input changes after the trigger.
      i_arm = 1; cycle(rnd_word(255)); i_arm = 0;
      for (int v = 1; v < 5; v++) cycle(rnd_word(255));
      i_decim = 4'd3; i_ext_trig = 1;
      t = hist.size(); cycle(rnd_word(255));
      i_ext_trig = 0; i_decim = 4'd0;
      cnt = 0;
      while (!o_done && cnt < 400) begin
         if (cnt == 19) i_arm = 1;
         cycle(rnd_word(255)); cnt++;
         i_arm = 0;
         if (cnt == 20) begin
            check("arm_ignored_state", o_state, 2);
            check("arm_ignored_cnt", o_wr_cnt, cnt / 4 + 1);
         end
      end
      check("decim_done_latency", cnt, (DEPTH - 1) * 4 + 1);
      check("decim_wr_cnt", o_wr_cnt, DEPTH);
      for (int k = DEPTH - 1; k >= 0; k--) rd(k, hist[t + 4 * k]);
      last_rd = hist[t];

      // Arm and trigger together from DONE, then trigger next cycle, abort at 17 words.
      i_arm = 1; i_ext_trig = 1; cycle(rnd_word(255)); i_arm = 0;
      check("armtrig_state", o_state, 1);
      check("armtrig_cnt", o_wr_cnt, 0);
      check("armtrig_done", o_done, 0);
      t = hist.size(); cycle(rnd_word(255)); i_ext_trig = 0;
      check("trig_next_state", o_state, 2);
      check("trig_next_cnt", o_wr_cnt, 1);
      i_rd_en = 1; i_rd_addr = '0; cycle(rnd_word(255)); i_rd_en = 0;
      check("rd_in_capture_valid", o_rd_valid, 0);
      check("rd_in_capture_hold", o_rd_data, last_rd);
      cnt = 0;
      while (o_wr_cnt != 17 && cnt < 100) begin cycle(rnd_word(255)); cnt++; end
      check("reach_17", o_wr_cnt, 17);
      i_abort = 1; cycle(rnd_word(255)); i_abort = 0;
      check("abort_state", o_state, 0);
      check("abort_cnt", o_wr_cnt, 17);
      check("abort_done", o_done, 0);
      rd(16, hist[t + 16]);
      check("abort_rd_valid", o_rd_valid, 1);
      for (int k = 0; k < 16; k++) rd(k, hist[t + k]);

      // Reset mid-capture; an external trigger afterwards must not write.
      i_arm = 1; cycle(rnd_word(255)); i_arm = 0;
      i_rd_en = 1; i_rd_addr = AW'(3); cycle(rnd_word(255)); i_rd_en = 0;
      check("rd_in_armed_valid", o_rd_valid, 0);
      i_ext_trig = 1; t = hist.size(); cycle(rnd_word(255)); i_ext_trig = 0;
      for (int k = 0; k < 10; k++) cycle(rnd_word(255));
      #2 rst = 1'b1;
      #1;
      check("rst_mid_state", o_state, 0);
      check("rst_mid_cnt", o_wr_cnt, 0);
      check("rst_mid_done", o_done, 0);
      check("rst_mid_rd_valid", o_rd_valid, 0);
      check("rst_mid_rd_data", o_rd_data, 0);
      #2 rst = 1'b0;
      @(posedge clk); #1;
      i_ext_trig = 1;
      for (int k = 0; k < 5; k++) cycle(rnd_word(255));
      i_ext_trig = 0;
      check("post_rst_state", o_state, 0);
      check("post_rst_cnt", o_wr_cnt, 0);
      rd(0, hist[t]);
      rd(5, hist[t + 5]);

`ifdef FE_CAP_THRESH_TRIG_EN
      // Threshold trigger: 0xBF samples never fire, a single 0xC0 in word 20 does.
      i_trig_sel = 1; i_trig_thresh = 8'hC0; i_ext_trig = 1;
      i_arm = 1; cycle(rnd_word(8'hBF)); i_arm = 0;
      for (int v = 1; v < 20; v++) begin
         w = rnd_word(8'hBF);
         w[$urandom_range(NUM_SAMP - 1, 0)] = 8'hBF;
         cycle(w);
      end
      check("thresh_bf_no_trig", o_state, 1);
      w = rnd_word(8'hBF);
      w[$urandom_range(NUM_SAMP - 1, 0)] = 8'hC0;
      t = hist.size(); cycle(w);
      check("thresh_trig_state", o_state, 2);
      i_abort = 1; cycle(rnd_word(8'hBF)); i_abort = 0;
      i_trig_sel = 0; i_ext_trig = 0;
      rd(0, hist[t]);
      rd(1, hist[t + 1]);
`endif

      repeat (3) cycle(rnd_word(255));
      check("rd_outstanding", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
